// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - cache refill responder backed by an on-chip word SRAM
//
// Serves icache line reads and dcache line reads / single-word byte-masked writes.
// One request is in flight at a time: accept -> fixed latency -> burst or write ack.
//
// Build option: MEM_RESP_RR_EN selects round-robin arbitration between the two
// request ports; left undefined, the dcache wins every tie.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   i_req_valid/ready/addr      icache line-read request
//   i_rsp_valid/data/last       icache refill beats
//   d_req_valid/ready/addr      dcache request
//   d_req_we/wdata/wstrb        dcache write select, data, byte enables
//   d_rsp_valid/data/last       dcache read beats or single write ack
module mem_responder #(
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 3,
   parameter int MEM_WORDS  = 16384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   output logic        i_req_ready,
   input  logic [31:0] i_req_addr,
   output logic        i_rsp_valid,
   output logic [31:0] i_rsp_data,
   output logic        i_rsp_last,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [31:0] d_req_addr,
   input  logic        d_req_we,
   input  logic [31:0] d_req_wdata,
   input  logic [3:0]  d_req_wstrb,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic        d_rsp_last
);

   localparam int AW   = $clog2(MEM_WORDS);
   localparam int LW   = $clog2(LINE_WORDS);
   localparam int CMAX = (LATENCY > LINE_WORDS) ? LATENCY : LINE_WORDS;
   localparam int CW   = $clog2(CMAX) + 1;

   typedef enum logic [1:0] {IDLE, WAIT, BURST, ACK} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic            sel_d;
   logic [AW-1:0]   widx;
   logic            we_q;
   logic [31:0]     wdata_q;
   logic [3:0]      wstrb_q;
   logic [31:0]     mem [MEM_WORDS];

   logic            grant_d, grant_i, accept;
   logic            lat_done, last_beat, beat_load, beat_is_last;
   logic [LW-1:0]   beat_nx;
   logic [AW-1:0]   rd_idx;
   logic [31:0]     rd_word;

   // Address bits outside the word index are intentionally ignored.
   wire unused_addr_bits = &{1'b0, i_req_addr[31:AW+2], i_req_addr[1:0],
                             d_req_addr[31:AW+2], d_req_addr[1:0]};

`ifdef MEM_RESP_RR_EN
   // rr_ptr=1 gives the dcache the next tie; it points away from the last grant.
   logic rr_ptr;
   assign grant_d = d_req_valid && (!i_req_valid || rr_ptr);
   always_ff @(posedge clk) begin
      if (!rst)
         rr_ptr <= 1'b0;
      else if (accept)
         rr_ptr <= !grant_d;
   end
`else
   assign grant_d = d_req_valid;
`endif
   assign grant_i = i_req_valid && !grant_d;

   assign i_req_ready = rst && (state == IDLE) && grant_i;
   assign d_req_ready = rst && (state == IDLE) && grant_d;
   assign accept      = i_req_ready || d_req_ready;

   assign lat_done     = (state == WAIT)  && (cnt == CW'(LATENCY - 1));
   assign last_beat    = (state == BURST) && (cnt == CW'(LINE_WORDS - 1));
   assign beat_is_last = (state == BURST) && (cnt == CW'(LINE_WORDS - 2));
   // A beat register load happens on WAIT exit (beat 0) and on every non-final BURST cycle.
   assign beat_load    = (lat_done && !we_q) || ((state == BURST) && !last_beat);

   // cnt holds the index of the beat currently on the bus while in BURST.
   assign beat_nx = (state == BURST) ? (cnt[LW-1:0] + LW'(1)) : '0;
   assign rd_idx  = {widx[AW-1:LW], beat_nx};
   assign rd_word = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)    state_nx = WAIT;
         WAIT:    if (lat_done)  state_nx = we_q ? ACK : BURST;
         BURST:   if (last_beat) state_nx = IDLE;
         ACK:                    state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt         <= '0;
         sel_d       <= 1'b0;
         widx        <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         i_rsp_valid <= 1'b0;
         i_rsp_data  <= '0;
         i_rsp_last  <= 1'b0;
         d_rsp_valid <= 1'b0;
         d_rsp_data  <= '0;
         d_rsp_last  <= 1'b0;
      end else begin
         if (accept) begin
            sel_d   <= grant_d;
            widx    <= grant_d ? d_req_addr[AW+1:2] : i_req_addr[AW+1:2];
            we_q    <= grant_d && d_req_we;
            wdata_q <= d_req_wdata;
            wstrb_q <= d_req_wstrb;
         end
         if (state == IDLE || lat_done)
            cnt <= '0;
         else if (state == WAIT || state == BURST)
            cnt <= cnt + CW'(1);

         i_rsp_valid <= beat_load && !sel_d;
         i_rsp_data  <= (beat_load && !sel_d) ? rd_word : 32'h0;
         i_rsp_last  <= beat_load && !sel_d && beat_is_last;
         d_rsp_valid <= (beat_load && sel_d) || (lat_done && we_q);
         d_rsp_data  <= (beat_load && sel_d) ? rd_word : 32'h0;
         d_rsp_last  <= (beat_load && sel_d && beat_is_last) || (lat_done && we_q);
      end
   end

   // Write commits on WAIT exit; a reset on that edge suppresses it.
   always_ff @(posedge clk) begin
      if (rst && lat_done && we_q) begin
         for (int k = 0; k < 4; k++) begin
            if (wstrb_q[k])
               mem[widx][8*k +: 8] <= wdata_q[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed bench for mem_responder
module tb_mem_responder;

   localparam int LW  = 4;
   localparam int LAT = 3;
   localparam int MW  = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req_valid = 1'b0, i_req_ready;
   logic [31:0] i_req_addr = '0;
   logic        i_rsp_valid, i_rsp_last;
   logic [31:0] i_rsp_data;
   logic        d_req_valid = 1'b0, d_req_ready;
   logic [31:0] d_req_addr = '0;
   logic        d_req_we = 1'b0;
   logic [31:0] d_req_wdata = '0;
   logic [3:0]  d_req_wstrb = '0;
   logic        d_rsp_valid, d_rsp_last;
   logic [31:0] d_rsp_data;

   mem_responder #(.LINE_WORDS(LW), .LATENCY(LAT), .MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_last(i_rsp_last),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
      .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_last(d_rsp_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: scheduled beats per interval, a busy horizon, a word array.
   typedef struct {int c; bit p; logic [31:0] d; bit l;} beat_t;
   typedef struct {int c; logic [31:0] d; bit l;} cap_t;
   beat_t       q[$];
   cap_t        cap_i[$], cap_d[$];
   logic [31:0] mm [MW];
   int          free_from = 0;
   bit          rr = 1'b0;
   bit          pend_v = 1'b0;
   int          pend_c, pend_idx;
   logic [31:0] pend_d;
   logic [3:0]  pend_s;

   always @(negedge clk) begin
      beat_t b;
      bit ev_i, ev_d, el_i, el_d, gd, gi, ri, rd, idle;
      logic [31:0] ed_i, ed_d;
      int a, idx, base;
      ev_i = 0; ev_d = 0; el_i = 0; el_d = 0; ed_i = '0; ed_d = '0;
      if (q.size() > 0 && q[0].c == cyc) begin
         b = q.pop_front();
         if (b.p) begin ev_d = 1; ed_d = b.d; el_d = b.l; end
         else     begin ev_i = 1; ed_i = b.d; el_i = b.l; end
      end
`ifdef MEM_RESP_RR_EN
      gd = d_req_valid && (!i_req_valid || rr);
`else
      gd = d_req_valid;
`endif
      gi   = i_req_valid && !gd;
      idle = rst && (cyc >= free_from);
      ri   = idle && gi;
      rd   = idle && gd;
      if (cyc >= 1) begin
         chk("i_req_ready", i_req_ready, ri);
         chk("d_req_ready", d_req_ready, rd);
         chk("i_rsp_valid", i_rsp_valid, ev_i);
         chk("i_rsp_data",  i_rsp_data,  ed_i);
         chk("i_rsp_last",  i_rsp_last,  el_i);
         chk("d_rsp_valid", d_rsp_valid, ev_d);
         chk("d_rsp_data",  d_rsp_data,  ed_d);
         chk("d_rsp_last",  d_rsp_last,  el_d);
      end
      if (i_rsp_valid === 1'b1) cap_i.push_back('{cyc, i_rsp_data, i_rsp_last});
      if (d_rsp_valid === 1'b1) cap_d.push_back('{cyc, d_rsp_data, d_rsp_last});

      if (!rst) begin
         q.delete();
         free_from = cyc + 1;
         rr = 1'b0;
         pend_v = 1'b0;
      end else begin
         if (pend_v && pend_c == cyc + 1) begin
            for (int k = 0; k < 4; k++)
               if (pend_s[k]) mm[pend_idx][8*k +: 8] = pend_d[8*k +: 8];
            pend_v = 1'b0;
         end
         if (ri || rd) begin
            a   = cyc + 1;
            idx = rd ? int'((d_req_addr >> 2) & (MW - 1)) : int'((i_req_addr >> 2) & (MW - 1));
            rr  = ri;
            if (rd && d_req_we) begin
               pend_v = 1'b1; pend_c = a + LAT; pend_idx = idx;
               pend_d = d_req_wdata; pend_s = d_req_wstrb;
               q.push_back('{a + LAT, 1'b1, 32'h0, 1'b1});
               free_from = a + LAT + 1;
            end else begin
               base = idx - (idx % LW);
               for (int n = 0; n < LW; n++)
                  q.push_back('{a + LAT + n, rd, mm[base + n], n == LW - 1});
               free_from = a + LAT + LW;
            end
         end
      end
   end

   int acc_i_cyc, acc_d_cyc;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present requests together; each is held until accepted.
   task automatic issue(input bit ip, input logic [31:0] ia, input bit dp, input logic [31:0] da,
                        input bit dwe, input logic [31:0] dwd, input logic [3:0] dst);
      bit pi, pd;
      int n;
      tick();
      pi = ip; pd = dp;
      i_req_valid = ip; i_req_addr = ia;
      d_req_valid = dp; d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd; d_req_wstrb = dst;
      n = 0;
      while ((pi || pd) && n < 200) begin
         @(negedge clk);
         if (pi && i_req_ready) begin pi = 0; acc_i_cyc = cyc + 1; end
         if (pd && d_req_ready) begin pd = 0; acc_d_cyc = cyc + 1; end
         tick();
         if (!pi) begin i_req_valid = 0; i_req_addr = $urandom; end
         if (!pd) begin
            d_req_valid = 0; d_req_addr = $urandom; d_req_we = 1'($urandom);
            d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
         end
         n++;
      end
      chk("accept_timeout", {30'h0, pi, pd}, 32'h0);
   endtask

   initial begin
      int n, n0;
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;

      for (int w = 0; w < MW; w++)
         issue(0, 0, 1, 32'(w * 4), 1, {16'hC0DE, 16'(w)}, 4'hF);
      repeat (10) tick();

      // Line read at 0x14: words 4..7, first beat LAT cycles after accept.
      cap_i.delete();
      issue(1, 32'h14, 0, 0, 0, 0, 0);
      repeat (12) tick();
      chk("rd_beats", cap_i.size(), 4);
      if (cap_i.size() == 4) begin
         chk("rd_first_lat", cap_i[0].c - acc_i_cyc, 3);
         chk("rd_beat0", cap_i[0].d, 32'hC0DE0004);
         chk("rd_beat3", cap_i[3].d, 32'hC0DE0007);
         chk("rd_last_early", {31'h0, cap_i[2].l}, 0);
         chk("rd_last", {31'h0, cap_i[3].l}, 1);
         chk("rd_gapless", cap_i[3].c - cap_i[0].c, 3);
      end

      // Masked write then read back.
      cap_d.delete();
      issue(0, 0, 1, 32'h40, 1, 32'hDEADBEEF, 4'b0011);
      issue(0, 0, 1, 32'h40, 0, 0, 0);
      repeat (12) tick();
      chk("wr_rd_beats", cap_d.size(), 5);
      if (cap_d.size() == 5) begin
         chk("wr_ack_data", cap_d[0].d, 0);
         chk("wr_ack_last", {31'h0, cap_d[0].l}, 1);
         chk("wr_readback", cap_d[1].d, 32'hC0DEBEEF);
      end

      // Zero strobe write is acked but changes nothing.
      cap_d.delete();
      issue(0, 0, 1, 32'h44, 1, 32'h12345678, 4'b0000);
      issue(0, 0, 1, 32'h44, 0, 0, 0);
      repeat (12) tick();
      if (cap_d.size() == 5) chk("wstrb0_keep", cap_d[1].d, 32'hC0DEBEEF);
      else chk("wstrb0_beats", cap_d.size(), 5);

`ifndef MEM_RESP_RR_EN
      // Tie: dcache first; icache held through the burst, accepted right after last beat.
      issue(1, 32'h20, 1, 32'h30, 0, 0, 0);
      chk("tie_order_gap", acc_i_cyc - acc_d_cyc, LAT + LW + 1);
`else
      issue(1, 32'h20, 1, 32'h30, 0, 0, 0);
      issue(1, 32'h20, 1, 32'h30, 0, 0, 0);
`endif
      repeat (10) tick();

      // Address wrap and last line.
      cap_i.delete();
      issue(1, 32'((MW * 4) + 32'h10), 0, 0, 0, 0, 0);
      repeat (10) tick();
      if (cap_i.size() >= 1) chk("wrap_beat0", cap_i[0].d, 32'hC0DE0004);
      else chk("wrap_beats", cap_i.size(), 4);
      cap_d.delete();
      issue(0, 0, 1, 32'hFC, 0, 0, 0);
      repeat (10) tick();
      if (cap_d.size() == 4) begin
         chk("lastline_b0", cap_d[0].d, 32'hC0DE003C);
         chk("lastline_b3", cap_d[3].d, 32'hC0DE003F);
      end else chk("lastline_beats", cap_d.size(), 4);

      // Reset in the middle of a burst.
      cap_i.delete();
      issue(1, 32'h28, 0, 0, 0, 0, 0);
      n = 0;
      while (cap_i.size() < 2 && n < 20) begin tick(); n++; end
      rst = 1'b0;
      tick();
      chk("rst_ivalid", {31'h0, i_rsp_valid}, 0);
      chk("rst_idata", i_rsp_data, 0);
      tick();
      rst = 1'b1;
      n0 = cap_i.size();
      repeat (10) tick();
      chk("rst_no_beats", cap_i.size(), n0);
      issue(1, 32'h08, 0, 0, 0, 0, 0);
      repeat (10) tick();

      // Randomized traffic with occasional resets.
      for (int it = 0; it < 150; it++) begin
         bit ip, dp;
         ip = 1'($urandom);
         dp = 1'($urandom);
         if (!ip && !dp) dp = 1'b1;
         issue(ip, $urandom, dp, $urandom, 1'($urandom), $urandom, 4'($urandom));
         repeat ($urandom_range(0, 6)) tick();
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
            rst = 1'b1;
         end
      end
      repeat (15) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
